muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_signfix.sv | 12 +
 rtl/muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes and FSM state encoding for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation: absolute value on the way in, result sign fix on the way out.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring shift-subtract step per cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_ZERO = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_opnd;
    logic             r_is_div;
    logic             r_skip;
    logic             r_dz;
    logic             r_neg_main;
    logic             r_neg_rem;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_zero;

    op_e              w_op;
    logic             w_accept;
    logic             w_in_div;
    logic             w_in_signed;
    logic             w_sa;
    logic             w_sb;
    logic             w_in_dz;
    logic             w_in_zero;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_op        = op_e'(op);
    assign w_accept    = (r_state == ST_IDLE) && start && !cancel;
    assign w_in_div    = (w_op == OP_DIV) || (w_op == OP_DIVU);
    assign w_in_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_sa        = w_in_signed && a[WIDTH-1];
    assign w_sb        = w_in_signed && b[WIDTH-1];
    assign w_in_dz     = w_in_div && (b == '0);
    assign w_in_zero   = (EARLY_ZERO != 0) && ((a == '0) || (!w_in_div && (b == '0)));

    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (.i_val(a), .i_neg(w_sa), .o_val(w_abs_a));
    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (.i_val(b), .i_neg(w_sb), .o_val(w_abs_b));

    // Multiply keeps the multiplier in r_quo and shifts the running sum into it;
    // divide shifts the dividend out of r_quo into r_rem and the quotient bits back in.
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;

    assign w_mul_sum   = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_opnd} : '0);
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, r_opnd};
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;

    always_comb begin
        w_step_rem = w_mul_sum[WIDTH:1];
        w_step_quo = {w_mul_sum[0], r_quo[WIDTH-1:1]};
        if (r_is_div) begin
            w_step_rem = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
            w_step_quo = {r_quo[WIDTH-2:0], w_div_ge};
        end
    end

    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    muldiv_signfix #(.WIDTH(2*WIDTH)) u_neg_prod (
        .i_val({w_step_rem, w_step_quo}), .i_neg(r_neg_main), .o_val(w_prod_fix));
    muldiv_signfix #(.WIDTH(WIDTH)) u_neg_quo (
        .i_val(w_step_quo), .i_neg(r_neg_main), .o_val(w_quo_fix));
    muldiv_signfix #(.WIDTH(WIDTH)) u_neg_rem (
        .i_val(w_step_rem), .i_neg(r_neg_rem), .o_val(w_rem_fix));

    always_comb begin
        // NOTE: next state defaults to the current one first, so no latch is inferred.
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_CALC;
            ST_CALC: begin
                if (cancel)                            w_state_nxt = ST_IDLE;
                else if (r_skip || r_cnt == LAST_STEP) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Zero-operand and divide-by-zero requests preload their final result and
    // spend a single cycle in CALC without iterating.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the datapath is reset too, so hi/lo read as zero straight out of reset.
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_skip     <= 1'b0;
            r_dz       <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_is_div   <= w_in_div;
            r_skip     <= w_in_dz || w_in_zero;
            r_dz       <= w_in_dz;
            r_neg_main <= w_sa ^ w_sb;
            r_neg_rem  <= w_sa;
            r_opnd     <= w_in_div ? w_abs_b : w_abs_a;
            if (w_in_dz) begin
                r_rem <= a;
                r_quo <= '1;
            end else if (w_in_zero) begin
                r_rem <= '0;
                r_quo <= '0;
            end else begin
                r_rem <= '0;
                r_quo <= w_in_div ? w_abs_a : w_abs_b;
            end
        end else if (r_state == ST_CALC && !cancel) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_skip) begin
                r_hi       <= r_rem;
                r_lo       <= r_quo;
                r_div_zero <= r_dz;
            end else begin
                r_rem <= w_step_rem;
                r_quo <= w_step_quo;
                if (r_cnt == LAST_STEP) begin
                    r_div_zero <= 1'b0;
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                end
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE) && !cancel;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, cancel/reset sequences, random ops vs arithmetic model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int          W       = 32;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic         start  = 1'b0;
    logic         cancel = 1'b0;
    logic [1:0]   op     = 2'b00;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;

    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
    logic         busy_nz, done_nz, dz_nz;
    logic [W-1:0] hi_nz, lo_nz;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .EARLY_ZERO(1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero));

    muldiv_unit #(.WIDTH(W), .EARLY_ZERO(0)) dut_nz (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
        .busy(busy_nz), .done(done_nz), .hi(hi_nz), .lo(lo_nz), .div_zero(dz_nz));

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dz;
        int           exp_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic add_vec(input string n, input logic [1:0] o, input logic [W-1:0] va, vb,
                           input logic [W-1:0] eh, el, input logic edz, input int ecyc);
        vec_t v;
        v.name = n; v.op = o; v.a = va; v.b = vb;
        v.exp_hi = eh; v.exp_lo = el; v.exp_dz = edz; v.exp_cyc = ecyc;
        vecs.push_back(v);
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
    // the remainder takes the dividend's sign, matching the required semantics.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] va, vb, input bit ez,
                                  output logic [W-1:0] eh, el, output logic edz, output int ecyc);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        bit              is_div;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        ua = {32'b0, va};
        ub = {32'b0, vb};
        is_div = o[1];
        edz = 1'b0;
        eh = '0;
        el = '0;
        if (is_div && vb == '0) begin
            eh = va; el = '1; edz = 1'b1;
        end else if (o == 2'b00) begin
            p = sa * sb; {eh, el} = p;
        end else if (o == 2'b01) begin
            up = ua * ub; {eh, el} = up;
        end else if (o == 2'b10) begin
            if (va == MIN_VAL && vb == '1) begin
                el = MIN_VAL; eh = '0;
            end else begin
                el = W'(sa / sb); eh = W'(sa % sb);
            end
        end else begin
            el = W'(ua / ub); eh = W'(ua % ub);
        end
        if (is_div && vb == '0)                          ecyc = 2;
        else if (ez && (va == '0 || (!is_div && vb == '0))) ecyc = 2;
        else                                             ecyc = W + 1;
    endfunction

    // Cycle 1 is the cycle that begins at the edge sampling start.
    task automatic run_op(input bit nz, input logic [1:0] o, input logic [W-1:0] va, vb,
                          output int cyc, output logic [W-1:0] rh, rl, output logic rdz,
                          output bit busy_ok);
        @(negedge clk);
        op = o; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!(nz ? done_nz : done) && cyc < 200) begin
            if (!(nz ? busy_nz : busy)) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (!(nz ? busy_nz : busy)) busy_ok = 1'b0;
        rh  = nz ? hi_nz : hi;
        rl  = nz ? lo_nz : lo;
        rdz = nz ? dz_nz : div_zero;
        @(posedge clk); #1;
    endtask

    task automatic watch_no_done(input int n, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
    endtask

    initial begin
        int           cyc;
        logic [W-1:0] rh, rl, eh, el;
        logic         rdz, edz;
        bit           bok, seen;
        int           ecyc;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;

        add_vec("mult_m3x5",   2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
        add_vec("multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        add_vec("div_m7d2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        add_vec("divu_7d0",    2'b11, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1, 2);
        add_vec("mult_zero_a", 2'b00, 32'd0,        32'h1234,     32'd0,        32'd0,        1'b0, 2);
        add_vec("div_min_m1",  2'b10, MIN_VAL,      32'hFFFFFFFF, 32'd0,        MIN_VAL,      1'b0, 33);
        add_vec("divu_100d7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33);
        add_vec("div_zero_a",  2'b10, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 2);
        add_vec("multu_zero_b",2'b01, 32'h12345678, 32'd0,        32'd0,        32'd0,        1'b0, 2);
        add_vec("div_7dm2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33);
        add_vec("div_5d0",     2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 2);
        add_vec("mult_min_sq", 2'b00, MIN_VAL,      MIN_VAL,      32'h40000000, 32'd0,        1'b0, 33);

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dz", div_zero, 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        foreach (vecs[i]) begin
            run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, cyc, rh, rl, rdz, bok);
            check({vecs[i].name, "_cyc"}, cyc, vecs[i].exp_cyc);
            check({vecs[i].name, "_hi"}, rh, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, rl, vecs[i].exp_lo);
            check({vecs[i].name, "_dz"}, rdz, vecs[i].exp_dz);
            check({vecs[i].name, "_busy"}, bok, 1);
            check({vecs[i].name, "_pulse"}, done, 0);
        end

        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = '0;
            if ($urandom_range(0, 15) == 0) begin ra = MIN_VAL; rb = '1; end
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 28);
            model(ro, ra, rb, 1'b1, eh, el, edz, ecyc);
            run_op(1'b0, ro, ra, rb, cyc, rh, rl, rdz, bok);
            check($sformatf("rnd%0d_cyc", i), cyc, ecyc);
            check($sformatf("rnd%0d_hi", i), rh, eh);
            check($sformatf("rnd%0d_lo", i), rl, el);
            check($sformatf("rnd%0d_dz", i), rdz, edz);
        end

        // Results hold after completion
        run_op(1'b0, 2'b01, 32'd3, 32'd4, cyc, rh, rl, rdz, bok);
        repeat (5) @(posedge clk);
        #1;
        check("hold_hi", hi, 0);
        check("hold_lo", lo, 12);

        // start and cancel together in IDLE: cancel wins
        @(negedge clk);
        op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("stcan_busy", busy, 0);
        watch_no_done(4, seen);
        check("stcan_nodone", seen, 0);
        check("stcan_lo", lo, 12);

        // Cancel 10 cycles into a MULTU, with an ignored start mid-CALC
        @(negedge clk);
        op = 2'b01; a = '1; b = '1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 4) begin op = 2'b11; a = 32'd5; b = 32'd0; start = 1'b1; end
            if (k == 5) start = 1'b0;
            @(posedge clk); #1;
            if (done || !busy) seen = 1'b1;
        end
        check("can_midop", seen, 0);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("can_busy", busy, 0);
        check("can_done", done, 0);
        watch_no_done(40, seen);
        check("can_nodone", seen, 0);
        check("can_hi", hi, 0);
        check("can_lo", lo, 12);
        check("can_dz", div_zero, 0);

        // Reset mid-operation
        @(negedge clk);
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("rmid_busy", busy, 0);
        check("rmid_done", done, 0);
        check("rmid_lo", lo, 0);
        watch_no_done(3, seen);
        check("rmid_nodone", seen, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        run_op(1'b0, 2'b11, 32'd100, 32'd7, cyc, rh, rl, rdz, bok);
        check("first_cyc", cyc, 33);
        check("first_lo", rl, 14);
        check("first_hi", rh, 2);

        // EARLY_ZERO=0 iterates through zero operands
        @(negedge clk); resetn = 1'b0;
        @(posedge clk); #1; resetn = 1'b1;
        run_op(1'b1, 2'b00, 32'd0, 32'h1234, cyc, rh, rl, rdz, bok);
        check("nz_cyc", cyc, 33);
        check("nz_hi", rh, 0);
        check("nz_lo", rl, 0);
        check("nz_busy", bok, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
